// File: rtl/pkt_gen_pkg.sv
// Shared types and LFSR helpers for the packet traffic generator.
// Imported by every channel instance and by the top.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        SANITY,
        BUFFER,
        MAX,
        MIN
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        PAYLOAD,
        PARITY,
        GAP,
        DONE
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] lfsr_seed(input logic [7:0] base,
                                             input int ch);
        logic [7:0] s;
        s = base ^ 8'(ch);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/pkt_gen_channel.sv
// One generator channel: packet FSM, payload LFSR and packet counter.
// Output bytes are decoded from registered state so they hold during stalls.
module pkt_gen_channel
    import pkt_gen_pkg::*;
#(
    parameter int         CH      = 0,
    parameter int         NUM_CH  = 4,
    parameter int         DATA_W  = 8,
    parameter int         MIN_LEN = 1,
    parameter int         MAX_LEN = 255,
    parameter int         IPG     = 2,
    parameter int         CNT_W   = 16,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  mode_e                     mode,
    input  logic [CNT_W-1:0]          num_pkts,
    input  logic [$clog2(NUM_CH)-1:0] dest_fixed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [CNT_W-1:0]          pkt_sent,
    output logic                      busy,
    output logic                      is_done
);

    localparam int         DEST_W = $clog2(NUM_CH);
    localparam int         GAP_W  = (IPG > 1) ? $clog2(IPG) : 1;
    localparam logic [7:0] SEED_C = lfsr_seed(SEED, CH);

    state_e              state;
    mode_e               mode_r;
    logic [CNT_W-1:0]    target;
    logic [7:0]          lfsr;
    logic [DATA_W-1:0]   len_r;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   par;
    logic [GAP_W-1:0]    gap;
    logic                stop_pend;

    logic [CNT_W:0]      dsum;
    logic [DEST_W-1:0]   dest;
    logic [DATA_W-1:0]   hdr;
    logic [DATA_W-1:0]   len_c;
    logic [DATA_W-1:0]   pay;
    logic [CNT_W-1:0]    cnt_inc;
    logic                xfer;
    logic                last;

    always_comb begin
        dsum = (CNT_W+1)'(CH) + {1'b0, pkt_sent};
        dest = (mode_r == BUFFER) ? dest_fixed
                                  : DEST_W'(dsum % (CNT_W+1)'(NUM_CH));
        hdr  = DATA_W'(dest);
        pay  = DATA_W'(lfsr);
        len_c = DATA_W'(MAX_LEN);
        unique case (mode_r)
            MIN:         len_c = DATA_W'(MIN_LEN);
            MAX, BUFFER: len_c = DATA_W'(MAX_LEN);
            SANITY: begin
                // LFSR holds still until PAYLOAD, so this is the HDR-entry value
                if ({24'b0, lfsr} < MIN_LEN)
                    len_c = DATA_W'(MIN_LEN);
                else if ({24'b0, lfsr} > MAX_LEN)
                    len_c = DATA_W'(MAX_LEN);
                else
                    len_c = DATA_W'(lfsr);
            end
            default:     len_c = DATA_W'(MAX_LEN);
        endcase
        cnt_inc = (&pkt_sent) ? pkt_sent : pkt_sent + CNT_W'(1);
        last    = (cnt_inc == target) | stop | stop_pend;
    end

    always_comb begin
        out_valid = state inside {HDR, LEN, PAYLOAD, PARITY};
        out_sop   = (state == HDR);
        out_eop   = (state == PARITY);
        out_data  = '0;
        unique case (state)
            HDR:     out_data = hdr;
            LEN:     out_data = len_r;
            PAYLOAD: out_data = pay;
            PARITY:  out_data = par;
            default: out_data = '0;
        endcase
        xfer    = out_valid & out_ready;
        busy    = !(state inside {IDLE, DONE});
        is_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_r    <= SANITY;
            target    <= '0;
            pkt_sent  <= '0;
            lfsr      <= SEED_C;
            len_r     <= '0;
            rem       <= '0;
            par       <= '0;
            gap       <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (stop && out_valid)
                stop_pend <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_r    <= mode;
                        target    <= num_pkts;
                        pkt_sent  <= '0;
                        stop_pend <= 1'b0;
                        state     <= (num_pkts == '0) ? DONE : HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        par   <= hdr;
                        len_r <= len_c;
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        par   <= par ^ len_r;
                        rem   <= len_r;
                        state <= (len_r == '0) ? PARITY : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        par  <= par ^ pay;
                        lfsr <= lfsr_next(lfsr);
                        rem  <= rem - DATA_W'(1);
                        if (rem == DATA_W'(1))
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        pkt_sent <= cnt_inc;
                        if (last)
                            state <= DONE;
                        else if (mode_r == BUFFER || IPG == 0)
                            state <= HDR;
                        else begin
                            gap   <= GAP_W'(IPG - 1);
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (stop || stop_pend)
                        state <= DONE;
                    else if (gap == '0)
                        state <= HDR;
                    else
                        gap <= gap - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pkt_traffic_gen.sv
// Multi-channel packet stimulus generator with runtime test mode.
// Instantiates NUM_CH channels and reduces their busy/done status.
module pkt_traffic_gen
    import pkt_gen_pkg::*;
#(
    parameter int         NUM_CH  = 4,
    parameter int         DATA_W  = 8,
    parameter int         MIN_LEN = 1,
    parameter int         MAX_LEN = 255,
    parameter int         IPG     = 2,
    parameter int         CNT_W   = 16,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                mode,
    input  logic [CNT_W-1:0]          num_pkts,
    input  logic [$clog2(NUM_CH)-1:0] dest_fixed,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*DATA_W-1:0]  out_data,
    output logic [NUM_CH-1:0]         out_sop,
    output logic [NUM_CH-1:0]         out_eop,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH*CNT_W-1:0]   pkt_sent
);

    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_done;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pkt_gen_channel #(
            .CH      (c),
            .NUM_CH  (NUM_CH),
            .DATA_W  (DATA_W),
            .MIN_LEN (MIN_LEN),
            .MAX_LEN (MAX_LEN),
            .IPG     (IPG),
            .CNT_W   (CNT_W),
            .SEED    (SEED)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .stop       (stop),
            .mode       (mode_e'(mode)),
            .num_pkts   (num_pkts),
            .dest_fixed (dest_fixed),
            .out_valid  (out_valid[c]),
            .out_ready  (out_ready[c]),
            .out_data   (out_data[c*DATA_W +: DATA_W]),
            .out_sop    (out_sop[c]),
            .out_eop    (out_eop[c]),
            .pkt_sent   (pkt_sent[c*CNT_W +: CNT_W]),
            .busy       (ch_busy[c]),
            .is_done    (ch_done[c])
        );
    end

    assign busy = |ch_busy;

    // start forces done low so a stale DONE is never seen after a relaunch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            done <= 1'b0;
        else
            done <= !start && (&ch_done);
    end

endmodule

// File: doc/pkt_traffic_gen.md
Name: pkt_traffic_gen

Overview:
- Synthesizable multi-channel packet stimulus generator, next generation of the router test harness.
- Replaces compile-time test selection (sanity / buffer / max-payload / min-payload) with a runtime mode input.
- Generalises to NUM_CH independent channels driving the router input ports with a valid/ready stream.
- Sits between the bench top and the DUT input interface, so one elaboration can run every regression mode.

Parameters:
- NUM_CH, 4, number of generator channels; also the number of router destination ports.
- DATA_W, 8, stream byte width.
- MIN_LEN, 1, payload length used in MIN mode; lower clamp in SANITY mode.
- MAX_LEN, 255, payload length used in MAX and BUFFER modes; upper clamp in SANITY mode; must fit in DATA_W bits.
- IPG, 2, idle cycles between packets (not used in BUFFER mode).
- CNT_W, 16, width of the packet counter.
- SEED, 8'hA5, per-channel LFSR seed base; channel c uses SEED ^ c, and 0 maps to 8'h01.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that launches a run on all channels.
- stop  input  1  pulse: each channel finishes its current packet, then goes to DONE.
- mode  input  2  0 SANITY, 1 BUFFER, 2 MAX, 3 MIN; sampled at start.
- num_pkts  input  CNT_W  packets per channel; sampled at start.
- dest_fixed  input  clog2(NUM_CH)  destination for all packets in BUFFER mode.
- out_valid  output  NUM_CH  per-channel byte valid.
- out_ready  input  NUM_CH  per-channel sink ready.
- out_data  output  NUM_CH*DATA_W  per-channel byte; channel c occupies bits [c*DATA_W +: DATA_W].
- out_sop  output  NUM_CH  marks the header byte.
- out_eop  output  NUM_CH  marks the parity byte.
- busy  output  1  OR of all channels not IDLE/DONE.
- done  output  1  all channels DONE; stays high until the next start.
- pkt_sent  output  NUM_CH*CNT_W  per-channel count of completed packets.

Behaviour:
- Reset (asynchronous, reset low):
  - all outputs 0; FSMs to IDLE; LFSRs to seed; counters 0.
  - Reset mid-packet truncates the packet with no eop.
- Packet format, one byte per transfer:
  - HDR = destination in the LSBs, zero-extended.
  - LEN = L.
  - L payload bytes = successive LFSR values (x^8+x^6+x^5+x^4+1), advanced only on a payload transfer.
  - PARITY = XOR of HDR, LEN and all payload bytes.
- Transfer occurs when out_valid & out_ready.
  - While out_valid is high and out_ready is low, out_data/sop/eop stay stable and the LFSR does not advance.
  - out_valid never drops without a transfer.
- Channel FSM:
  - IDLE -start-> HDR.
  - HDR -xfer-> LEN -xfer-> PAYLOAD; PAYLOAD stays until L transfers, then -> PARITY.
  - PARITY -xfer-> GAP, or DONE when pkt_sent reaches num_pkts or stop is pending.
  - GAP: IPG cycles with out_valid = 0 -> HDR. BUFFER mode and IPG = 0 skip GAP.
  - DONE -start-> HDR. start in any other state is ignored.
- start with num_pkts = 0: DONE on the next cycle; no valid asserted.
- The first HDR is valid on the cycle after start.
- Length per mode:
  - MIN: MIN_LEN.
  - MAX and BUFFER: MAX_LEN.
  - SANITY: the current LFSR byte clamped to [MIN_LEN, MAX_LEN], sampled when entering HDR.
- Destination:
  - BUFFER: dest_fixed.
  - Other modes: (c + pkt_sent[c]) mod NUM_CH.
- pkt_sent increments on the PARITY transfer and saturates at all-ones.
- stop:
  - In HDR/LEN/PAYLOAD, the packet completes fully.
  - In GAP, go to DONE immediately.
  - Same cycle as the final PARITY transfer: DONE, counted normally.
- done = AND of per-channel DONE, registered; cleared the cycle after start.

Decomposition:
- Package pkt_gen_pkg holds:
  - typedef enum mode_e {SANITY, BUFFER, MAX, MIN};
  - typedef enum state_e {IDLE, HDR, LEN, PAYLOAD, PARITY, GAP, DONE};
  - LFSR tap constant;
  - function lfsr_next().
- Sub-module pkt_gen_channel: one FSM + LFSR + counters. The top generates NUM_CH instances and reduces busy/done.

Test Plan:
- MIN, num_pkts = 3, ready tied high:
  - each channel emits 3 packets of 4 bytes (HDR, LEN = 1, one payload, PARITY);
  - each packet is followed by 2 idle cycles;
  - channel 1 destinations are 1, 2, 3;
  - done after the final eop; pkt_sent = 3 each.
- MAX, num_pkts = 1, ready toggling 1010...:
  - 258 transfers; bytes stable during stalls;
  - parity byte equals the XOR that the bench computes.
- BUFFER, dest_fixed = 2, num_pkts = 4:
  - HDR = 2 on all channels;
  - no gap cycles: the next sop follows the eop on the next cycle.
- SANITY with SEED = 0:
  - LFSR seeded 8'h01 on channel 0;
  - every LEN is within [1, 255] and matches the bench LFSR model.
- stop during payload of packet 2 of 10:
  - packet 2 completes with eop, then DONE;
  - pkt_sent = 2; a start during the run is ignored.
- reset low mid-PAYLOAD:
  - out_valid = 0 asynchronously, counters 0;
  - a new start after reset release yields a full clean run.
